// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, sub-word load extraction and
// register-file write-port generation for the 5-stage MIPS pipeline.
module wb_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        MEMtoWB_Valid,
   input  logic [31:0] MEMtoWB_PC,
   input  logic [31:0] MEMtoWB_ALUResult,
   input  logic [31:0] MEMtoWB_ReadData,
   input  logic [4:0]  MEMtoWB_Rd,
   input  logic        MEMtoWB_RegWrite,
   input  logic        MEMtoWB_MemtoReg,
   input  logic        MEMtoWB_Link,
   input  logic [2:0]  MEMtoWB_LoadType,
   output logic [4:0]  writeReg,
   output logic [31:0] writeData,
   output logic        RegWrite,
   output logic [31:0] WB_PC,
   output logic        misaligned,
   output logic [31:0] retired_count
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned BYTE_W = 8;

   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LHU = 3'b010;
   localparam logic [2:0] LT_LB  = 3'b011;
   localparam logic [2:0] LT_LBU = 3'b100;

   logic              valid;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   alu;
   logic [XLEN-1:0]   rdata;
   logic [4:0]        rd;
   logic              regwrite;
   logic              memtoreg;
   logic              link;
   logic [2:0]        loadtype;
   logic              done;

   logic [1:0]        off;
   logic [HALF_W-1:0] half_sel;
   logic [BYTE_W-1:0] byte_sel;
   logic [XLEN-1:0]   load_data;
   logic              is_half;
   logic              is_word;

   // MEM/WB register: reset > flush > stall > load; done blocks repeat writes while stalled
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid    <= 1'b0;
         pc       <= RESET_PC;
         alu      <= '0;
         rdata    <= '0;
         rd       <= '0;
         regwrite <= 1'b0;
         memtoreg <= 1'b0;
         link     <= 1'b0;
         loadtype <= '0;
         done     <= 1'b0;
         if (rst) begin
            retired_count <= '0;
         end
      end else if (stall) begin
         done <= done | RegWrite;
      end else begin
         valid    <= MEMtoWB_Valid;
         pc       <= MEMtoWB_PC;
         alu      <= MEMtoWB_ALUResult;
         rdata    <= MEMtoWB_ReadData;
         rd       <= MEMtoWB_Rd;
         regwrite <= MEMtoWB_RegWrite;
         memtoreg <= MEMtoWB_MemtoReg;
         link     <= MEMtoWB_Link;
         loadtype <= MEMtoWB_LoadType;
         done     <= 1'b0;
         if (MEMtoWB_Valid) begin
            retired_count <= retired_count + XLEN'(1);
         end
      end
   end

   // Sub-word load extraction; unknown load codes behave as lw
   always_comb begin
      off      = alu[1:0];
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];
      byte_sel = rdata[7:0];
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      is_half = 1'b0;
      is_word = 1'b0;
      case (loadtype)
         LT_LH: begin
            load_data = {{(XLEN-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            is_half   = 1'b1;
         end
         LT_LHU: begin
            load_data = {{(XLEN-HALF_W){1'b0}}, half_sel};
            is_half   = 1'b1;
         end
         LT_LB:   load_data = {{(XLEN-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
         LT_LBU:  load_data = {{(XLEN-BYTE_W){1'b0}}, byte_sel};
         default: begin
            load_data = rdata;
            is_word   = 1'b1;
         end
      endcase
   end

   // Write-port generation from the held entry
   always_comb begin
      misaligned = valid & memtoreg & ((is_word & (off != 2'd0)) | (is_half & off[0]));
      writeReg   = link ? 5'd31 : rd;
      if (link) begin
         writeData = pc + XLEN'(4);
      end else if (memtoreg) begin
         writeData = load_data;
      end else begin
         writeData = alu;
      end
      RegWrite = valid & regwrite & ~done & ~misaligned & (writeReg != 5'd0);
      WB_PC    = pc;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 5-stage MIPS pipeline. It registers the MEM/WB pipeline contents, extracts and extends sub-word load data, and selects the write-back value. It then drives the register-file write port (`writeReg`, `writeData`, `RegWrite`) that the decode stage consumes. It also handles stall and flush, suppresses duplicate writes while stalled, flags misaligned loads, and counts retired instructions.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000, value `WB_PC` holds after reset or flush.

Ports:
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `stall`  input  1  hold the current WB entry and do not load a new one.
- `flush`  input  1  load a bubble (valid=0) on the next edge.
- `MEMtoWB_Valid`  input  1  the incoming entry is a real instruction.
- `MEMtoWB_PC`  input  32  PC of the incoming instruction.
- `MEMtoWB_ALUResult`  input  32  ALU result; for loads, the byte address.
- `MEMtoWB_ReadData`  input  32  raw data-memory word, little-endian.
- `MEMtoWB_Rd`  input  5  destination register, already chosen by RegDst.
- `MEMtoWB_RegWrite`  input  1  the instruction writes the register file.
- `MEMtoWB_MemtoReg`  input  1  select load data instead of the ALU result.
- `MEMtoWB_Link`  input  1  jal/jalr: write PC+4 to `$31`.
- `MEMtoWB_LoadType`  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; other codes are treated as lw.
- `writeReg`  output  5  register-file write address.
- `writeData`  output  32  register-file write data.
- `RegWrite`  output  1  register-file write enable.
- `WB_PC`  output  32  PC of the entry held in WB (debug).
- `misaligned`  output  1  the held load is misaligned.
- `retired_count`  output  32  number of valid instructions that entered WB.

## Operation

- Pipeline register fields: valid, pc, alu, rdata, rd, regwrite, memtoreg, link, loadtype, plus an internal `done` flag.
- Update priority at each rising edge, highest first:
  - `rst`: valid=0, done=0, pc=`RESET_PC`, all other fields 0, `retired_count`=0.
  - `flush`: same as reset except `retired_count` is held.
  - `stall`: hold all fields. `done` becomes 1 if `RegWrite` was 1 in this cycle.
  - Otherwise: load all MEMtoWB_* fields, set done=0, and add 1 to `retired_count` if `MEMtoWB_Valid`=1. The counter wraps modulo 2^32.
- Load extraction uses `off` = `alu[1:0]`:
  - lw: the full word.
  - lh / lhu: the half at `rdata[16*off[1]+15 : 16*off[1]]`, sign-extended for lh, zero-extended for lhu.
  - lb / lbu: the byte at `rdata[8*off+7 : 8*off]`, sign-extended for lb, zero-extended for lbu.
- `misaligned` = valid & memtoreg & (lw with off≠0, or lh/lhu with off[0]=1).
- Outputs are combinational from the registered fields:
  - `writeReg` = link ? 5'd31 : rd.
  - `writeData` = link ? pc+4 : memtoreg ? extracted load data : alu. PC+4 wraps modulo 2^32.
  - `RegWrite` = valid & regwrite & ~done & ~misaligned & (`writeReg`≠0).
- Register 0 is never written, because `RegWrite` is forced to 0 when `writeReg`=0.

## Timing

- Latency: one clock. An entry presented at edge N drives `writeReg`/`writeData`/`RegWrite` during cycle N to N+1. The register file commits it at edge N+1.
- `RegWrite` is high for exactly one cycle per valid writing entry, regardless of how long `stall` is held.
- `flush` and `stall` asserted together: flush wins.
- `rst` asserted at any point, including mid-stall, overrides everything. All outputs are 0 in the cycle after the reset edge, except `WB_PC`=`RESET_PC`.
- Outputs while valid=0: `RegWrite`=0 and `misaligned`=0. `writeReg` and `writeData` follow the held fields and are don't-care.
- Inputs are sampled only at the rising edge. There is no combinational path from MEMtoWB_* to the outputs.

## Test plan

- Reset: hold `rst` for 2 cycles with random inputs → `RegWrite`=0, `retired_count`=0, `WB_PC`=0, `misaligned`=0.
- R-type: Valid=1, RegWrite=1, MemtoReg=0, Rd=8, ALUResult=32'h0000_00FF → the next cycle shows writeReg=8, writeData=32'h0000_00FF, RegWrite=1, and count increments by 1.
- Sub-word loads: ReadData=32'h80F1_7F22, MemtoReg=1, Rd=9. Expected `writeData` per case:
  - lb, addr …03 → 32'hFFFF_FF80.
  - lbu, addr …03 → 32'h0000_0080.
  - lh, addr …02 → 32'hFFFF_80F1.
  - lhu, addr …00 → 32'h0000_7F22.
  - lw, addr …02 → `misaligned`=1 and `RegWrite`=0.
- jal: Link=1, PC=32'h0040_0010 → writeReg=31, writeData=32'h0040_0014, RegWrite=1.
- Stall: load a writing entry, then hold `stall` for 3 cycles → `RegWrite` is high only in the first cycle, the outputs stay held, and count increments only once.
- Flush and $zero:
  - Assert `flush` and `stall` together with a valid input → a bubble loads, `RegWrite`=0, and count is unchanged.
  - A writing entry with Rd=0 → `RegWrite`=0.
